fpga_bootrom_bus_adapter: RTL and testbench

FPGA_BOOTROM_BUS_ADAPTER -- requirements
Module: fpga_bootrom_bus_adapter

---
 rtl/fpga_bootrom_pkg.sv | 15 +
 rtl/fpga_bootrom_bus_adapter.sv | 138 +++++++++++++
 tb/tb_fpga_bootrom_bus_adapter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fpga_bootrom_pkg.sv
// Shared types and constants for the FPGA boot-ROM bus adapter.
package fpga_bootrom_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StResp = 2'd2
   } bootrom_adapter_state_e;

   localparam int unsigned ROM_LATENCY_MAX = 4;

   // Jump-to-self instruction, handy as a parking word in boot ROM images.
   localparam logic [31:0] JAL_SELF = 32'h0000006F;

endpackage

// File: rtl/fpga_bootrom_bus_adapter.sv
// Adapts a req/gnt/r_valid bus to a synchronous read-only ROM with a
// configurable clock-to-Q latency. Reads are forwarded to the ROM. Writes never
// touch the ROM and are answered on the next cycle.
// Optional feature: define FPGA_BOOTROM_WRITE_ERR_EN to flag write responses
// with r_opc_o=1. Without it, writes are acknowledged silently.
module fpga_bootrom_bus_adapter #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ROM_ADDR_WIDTH = 10,
   parameter int unsigned ROM_LATENCY    = 1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      req_i,
   output logic                      gnt_o,
   input  logic [ADDR_WIDTH-1:0]     add_i,
   input  logic                      wen_i,
   input  logic [DATA_WIDTH/8-1:0]   be_i,
   input  logic [DATA_WIDTH-1:0]     wdata_i,
   output logic                      r_valid_o,
   output logic [DATA_WIDTH-1:0]     r_rdata_o,
   output logic                      r_opc_o,
   output logic                      rom_cen_o,
   output logic [ROM_ADDR_WIDTH-1:0] rom_a_o,
   input  logic [DATA_WIDTH-1:0]     rom_q_i
);

   import fpga_bootrom_pkg::*;

   localparam int unsigned CntW = $clog2(ROM_LATENCY_MAX);
   localparam logic [CntW-1:0] CntLoad = CntW'(ROM_LATENCY - 1);

   bootrom_adapter_state_e    state_q, state_d;
   logic [CntW-1:0]           cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
   logic [ROM_ADDR_WIDTH-1:0] rom_a_q, rom_a_d;
   logic [ROM_ADDR_WIDTH-1:0] rom_addr;
   logic                      gnt;
   logic                      rd_accept;
   logic                      wr_accept;
   logic                      rd_done;

   // Byte offset and bits above the ROM size are dropped, so addresses wrap.
   assign rom_addr = add_i[ROM_ADDR_WIDTH+1:2];

   // Byte enables, write data and out-of-range address bits carry no meaning here.
   logic unused_sig;
   assign unused_sig = ^{be_i, wdata_i, add_i};

   // Next-state, grant and ROM strobe decode.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rdata_d   = rdata_q;
      rom_a_d   = rom_a_q;
      gnt       = 1'b0;
      rd_accept = 1'b0;
      wr_accept = 1'b0;
      rd_done   = 1'b0;

      unique case (state_q)
         StIdle, StResp: begin
            // Reset gating keeps the ROM strobe quiet while rst_i is held.
            gnt       = req_i & ~rst_i;
            rd_accept = gnt & wen_i;
            wr_accept = gnt & ~wen_i;
            state_d   = StIdle;
            if (rd_accept) begin
               rom_a_d = rom_addr;
               cnt_d   = CntLoad;
               state_d = StWait;
            end else if (wr_accept) begin
               rdata_d = '0;
               state_d = StResp;
            end
         end
         StWait: begin
            if (cnt_q == '0) begin
               rd_done = 1'b1;
               rdata_d = rom_q_i;
               state_d = StResp;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign gnt_o     = gnt;
   assign rom_cen_o = ~rd_accept;
   assign rom_a_o   = rd_accept ? rom_addr : rom_a_q;
   assign r_valid_o = (state_q == StResp);
   assign r_rdata_o = rdata_q;

   // State, latency counter, read data and held ROM address.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         rdata_q <= '0;
         rom_a_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         rom_a_q <= rom_a_d;
      end
   end

`ifdef FPGA_BOOTROM_WRITE_ERR_EN
   logic opc_q, opc_d;

   // Error flag: set by an accepted write, cleared by a completed read.
   always_comb begin
      opc_d = opc_q;
      if (wr_accept) begin
         opc_d = 1'b1;
      end else if (rd_done) begin
         opc_d = 1'b0;
      end
   end

   // Error flag register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         opc_q <= 1'b0;
      end else begin
         opc_q <= opc_d;
      end
   end

   assign r_opc_o = r_valid_o & opc_q;
`else
   assign r_opc_o = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_bootrom_bus_adapter.sv
// Bench for fpga_bootrom_bus_adapter: two instances (ROM latency 1 and 3) share
// one directed stimulus stream and are checked against a transaction-level model.
module tb_fpga_bootrom_bus_adapter;
   import fpga_bootrom_pkg::*;

`ifdef FPGA_BOOTROM_WRITE_ERR_EN
   localparam logic WR_OPC = 1'b1;
`else
   localparam logic WR_OPC = 1'b0;
`endif

   localparam int LAT [2] = '{1, 3};

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_i;
   logic [31:0] add_i;
   logic        wen_i;
   logic [3:0]  be_i;
   logic [31:0] wdata_i;

   logic        gnt   [2];
   logic        valid [2];
   logic [31:0] rdata [2];
   logic        opc   [2];
   logic        cen   [2];
   logic [9:0]  rom_a [2];
   logic [31:0] rom_q [2];

   int total  = 0;
   int passed = 0;

   always #5 clk_i = ~clk_i;

   fpga_bootrom_bus_adapter #(.ROM_LATENCY(1)) u_dut1 (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt[0]), .add_i(add_i),
      .wen_i(wen_i), .be_i(be_i), .wdata_i(wdata_i), .r_valid_o(valid[0]),
      .r_rdata_o(rdata[0]), .r_opc_o(opc[0]), .rom_cen_o(cen[0]), .rom_a_o(rom_a[0]),
      .rom_q_i(rom_q[0])
   );

   fpga_bootrom_bus_adapter #(.ROM_LATENCY(3)) u_dut3 (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt[1]), .add_i(add_i),
      .wen_i(wen_i), .be_i(be_i), .wdata_i(wdata_i), .r_valid_o(valid[1]),
      .r_rdata_o(rdata[1]), .r_opc_o(opc[1]), .rom_cen_o(cen[1]), .rom_a_o(rom_a[1]),
      .rom_q_i(rom_q[1])
   );

   // ROM image: word 0x020 holds JAL_SELF, every other word encodes its own address.
   function automatic logic [31:0] rom_word(input logic [9:0] a);
      return (a == 10'h020) ? JAL_SELF : (32'hC0DE0000 | {22'b0, a});
   endfunction

   // Behavioural ROMs: data appears LAT cycles after an enabled address.
   logic [31:0] r1_s0, r3_s0, r3_s1, r3_s2;
   always @(posedge clk_i) begin
      if (!cen[0]) r1_s0 <= rom_word(rom_a[0]);
      if (!cen[1]) r3_s0 <= rom_word(rom_a[1]);
      r3_s1 <= r3_s0;
      r3_s2 <= r3_s1;
   end
   assign rom_q[0] = r1_s0;
   assign rom_q[1] = r3_s2;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Transaction model: a read granted at t answers at t+LAT+1, a write at t+1;
   // the next grant is possible from the response cycle on.
   int          cyc = 0;
   int          avail    [2] = '{0, 0};
   int          resp_cyc [2] = '{-1, -1};
   logic [31:0] pend_data[2];
   logic        pend_opc [2];
   logic [31:0] exp_rdata[2] = '{32'h0, 32'h0};
   logic [9:0]  last_a   [2] = '{10'h0, 10'h0};

   always @(negedge clk_i) begin
      for (int i = 0; i < 2; i++) begin
         string tag;
         tag = $sformatf("lat%0d c%0d", LAT[i], cyc);
         if (rst_i) begin
            check({tag, " rst valid"}, 32'(valid[i]), 32'd0);
            check({tag, " rst rdata"}, rdata[i], 32'd0);
            check({tag, " rst opc"}, 32'(opc[i]), 32'd0);
            check({tag, " rst cen"}, 32'(cen[i]), 32'd1);
            check({tag, " rst rom_a"}, 32'(rom_a[i]), 32'd0);
            avail[i]     = 0;
            resp_cyc[i]  = -1;
            exp_rdata[i] = '0;
            last_a[i]    = '0;
         end else begin
            logic       eg, ev, erd;
            logic [9:0] slice;
            slice = 10'((add_i >> 2) & 32'h3FF);
            eg    = req_i && (cyc >= avail[i]);
            erd   = eg && wen_i;
            ev    = (cyc == resp_cyc[i]);
            if (ev) exp_rdata[i] = pend_data[i];
            check({tag, " gnt"}, 32'(gnt[i]), 32'(eg));
            check({tag, " valid"}, 32'(valid[i]), 32'(ev));
            check({tag, " rdata"}, rdata[i], exp_rdata[i]);
            if (ev) check({tag, " opc"}, 32'(opc[i]), 32'(pend_opc[i]));
            check({tag, " cen"}, 32'(cen[i]), 32'(!erd));
            check({tag, " rom_a"}, 32'(rom_a[i]), 32'(erd ? slice : last_a[i]));
            if (erd) begin
               resp_cyc[i]  = cyc + LAT[i] + 1;
               avail[i]     = resp_cyc[i];
               pend_data[i] = rom_word(slice);
               pend_opc[i]  = 1'b0;
               last_a[i]    = slice;
            end else if (eg) begin
               resp_cyc[i]  = cyc + 1;
               avail[i]     = cyc + 1;
               pend_data[i] = '0;
               pend_opc[i]  = WR_OPC;
            end
         end
      end
      cyc++;
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int n);
      req_i = 1'b0;
      repeat (n) tick();
   endtask

   int exp_g3 [14] = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
   int exp_v3 [14] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0};

   initial begin
      rst_i   = 1'b1;
      req_i   = 1'b0;
      add_i   = '0;
      wen_i   = 1'b1;
      be_i    = 4'hF;
      wdata_i = '0;
      repeat (3) tick();
      rst_i = 1'b0;
      idle(2);

      // Single read at 0x1A000080 on the latency-1 instance.
      req_i = 1'b1; wen_i = 1'b1; add_i = 32'h1A000080;
      #1;
      check("A gnt c0", 32'(gnt[0]), 32'd1);
      check("A cen c0", 32'(cen[0]), 32'd0);
      check("A rom_a c0", 32'(rom_a[0]), 32'h020);
      tick();
      req_i = 1'b0;
      #1;
      check("A valid c1", 32'(valid[0]), 32'd0);
      check("A rom_a hold c1", 32'(rom_a[0]), 32'h020);
      tick();
      #1;
      check("A valid c2", 32'(valid[0]), 32'd1);
      check("A rdata c2", rdata[0], 32'h0000006F);
      check("A opc c2", 32'(opc[0]), 32'd0);
      idle(8);

      // req held for three reads on the latency-3 instance.
      add_i = 32'h00000008; wen_i = 1'b1;
      for (int c = 0; c < 14; c++) begin
         req_i = (c <= 8);
         #1;
         check($sformatf("B gnt3 c%0d", c), 32'(gnt[1]), 32'(exp_g3[c]));
         check($sformatf("B valid3 c%0d", c), 32'(valid[1]), 32'(exp_v3[c]));
         if (exp_v3[c] == 1) check($sformatf("B rdata3 c%0d", c), rdata[1], 32'hC0DE0002);
         tick();
      end
      idle(6);

      // Write: no ROM access, answered next cycle with zero data.
      req_i = 1'b1; wen_i = 1'b0; add_i = 32'h1A000000; wdata_i = 32'hDEADBEEF;
      #1;
      check("C gnt c0", 32'(gnt[0]), 32'd1);
      check("C cen c0", 32'(cen[0]), 32'd1);
      tick();
      req_i = 1'b0;
      #1;
      check("C cen c1", 32'(cen[0]), 32'd1);
      check("C valid c1", 32'(valid[0]), 32'd1);
      check("C opc c1", 32'(opc[0]), 32'(WR_OPC));
      check("C rdata c1", rdata[0], 32'd0);
      check("C valid3 c1", 32'(valid[1]), 32'd1);
      idle(6);

      // Address wrap: 0x1004 and 0x0004 select the same ROM word.
      wen_i = 1'b1; wdata_i = '0;
      req_i = 1'b1; add_i = 32'h00001004;
      #1;
      check("D rom_a 0x1004", 32'(rom_a[0]), 32'h001);
      check("D rom_a3 0x1004", 32'(rom_a[1]), 32'h001);
      tick();
      idle(6);
      req_i = 1'b1; add_i = 32'h00000004;
      #1;
      check("D rom_a 0x0004", 32'(rom_a[0]), 32'h001);
      tick();
      idle(6);

      // Reset during WAIT drops the pending response.
      req_i = 1'b1; wen_i = 1'b1; add_i = 32'h00000010;
      tick();
      req_i = 1'b0;
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      for (int k = 0; k < 10; k++) begin
         #1;
         check($sformatf("E valid k%0d", k), 32'(valid[0]), 32'd0);
         check($sformatf("E valid3 k%0d", k), 32'(valid[1]), 32'd0);
         check($sformatf("E cen k%0d", k), 32'(cen[0]), 32'd1);
         tick();
      end

      idle(3);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
